// File: rtl/branch_resolve_unit.sv
// Execute-stage RV32I branch resolver: registered outcome/next PC, misprediction flag,
// bimodal 2-bit BHT trained on resolution, and saturating performance counters.
module branch_resolve_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_pred_taken,
  input  logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic [XLEN-1:0]   res_next_pc,
  output logic              res_mispredict,
  output logic              res_illegal,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             taken_next;
  logic             illegal_next;
  logic             mispredict_next;
  logic [XLEN-1:0]  next_pc_next;
  logic             fire;
  logic             train;
  logic [1:0]       bht_reg [BHT_ENTRIES];
  logic             unused_pred_bits;

  assign pred_idx         = pred_pc[IDX_W+1:2];
  assign ex_idx           = ex_pc[IDX_W+1:2];
  assign unused_pred_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  // Lookup reads the stored counter only; same-cycle training is not bypassed.
  assign pred_taken = bht_reg[pred_idx][1];

  always_comb begin
    taken_next   = 1'b0;
    illegal_next = 1'b0;
    case (ex_funct3)
      3'b000:  taken_next = (ex_rs1 == ex_rs2);
      3'b001:  taken_next = (ex_rs1 != ex_rs2);
      3'b100:  taken_next = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  taken_next = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  taken_next = (ex_rs1 <  ex_rs2);
      3'b111:  taken_next = (ex_rs1 >= ex_rs2);
      default: illegal_next = 1'b1;
    endcase
  end

  assign mispredict_next = ~illegal_next & (taken_next ^ ex_pred_taken);
  assign next_pc_next    = taken_next ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
  assign fire            = ex_valid & ~flush;
  assign train           = fire & ~illegal_next;

  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bht_reg[gi] <= CNT_INIT;
        end else if (train && ex_idx == IDX_W'(gi)) begin
          if (taken_next && bht_reg[gi] != 2'b11)
            bht_reg[gi] <= bht_reg[gi] + 2'b01;
          else if (!taken_next && bht_reg[gi] != 2'b00)
            bht_reg[gi] <= bht_reg[gi] - 2'b01;
        end
      end
    end
  endgenerate

  // Result payload holds its last value while no branch fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_next_pc    <= '0;
      res_mispredict <= 1'b0;
      res_illegal    <= 1'b0;
    end else begin
      res_valid <= fire;
      if (fire) begin
        res_taken      <= taken_next;
        res_next_pc    <= next_pc_next;
        res_mispredict <= mispredict_next;
        res_illegal    <= illegal_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (train) begin
      if (perf_branches != '1)
        perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict_next && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule
